// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared opcodes and FSM state for the SPI command RAM
package spi_ram_pkg;
  localparam logic [1:0] OP_SET_WADDR = 2'b00;
  localparam logic [1:0] OP_WRITE     = 2'b01;
  localparam logic [1:0] OP_SET_RADDR = 2'b10;
  localparam logic [1:0] OP_READ      = 2'b11;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/spi_ram_burst_ram.sv
// ram_sp_array: single-port storage with a synchronous write port and an enabled, holding read register
module ram_sp_array #(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;
  // array itself is never reset; contents are undefined after power-up
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  // read register loads only on re so it holds the presented word under back-pressure
  always_comb rdata_d = re ? mem_q[raddr] : rdata_q;
  // read register is the block's dout and clears on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/spi_ram_burst.sv
// spi_ram_burst: command decoder, address counters and read-burst FSM in front of the command RAM
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              err
);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [DATA_W:0]   DEPTH_V = (DATA_W + 1)'(MEM_DEPTH);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] awr_q, awr_d, ard_q, ard_d, rem_q, rem_d;
  logic              tx_valid_q, tx_valid_d, err_q, err_d;
  logic [1:0]        op;
  logic [DATA_W-1:0] pl;
  logic              acc, in_range, pop, re, we;
  function automatic logic [ADDR_W-1:0] adv(input logic [ADDR_W-1:0] a);
    return (AUTO_INC == 0) ? a : (a == LAST_A) ? '0 : a + 1'b1;
  endfunction
  assign op       = din[DATA_W+1:DATA_W];
  assign pl       = din[DATA_W-1:0];
  assign acc      = rx_valid && (state_q == IDLE);
  assign in_range = {1'b0, pl} < DEPTH_V;
  assign pop      = (state_q == SEND) && tx_ready;
  assign re       = (acc && (op == OP_READ)) || (pop && (rem_q != '0));
  assign we       = acc && (op == OP_WRITE);
  // next-state: commands decode only in IDLE, SEND advances one word per accepted beat
  always_comb begin
    state_d    = state_q;
    awr_d      = awr_q;
    ard_d      = ard_q;
    rem_d      = rem_q;
    tx_valid_d = tx_valid_q;
    err_d      = err_q;
    if (acc) begin
      if (op == OP_SET_WADDR) begin
        awr_d = in_range ? pl[ADDR_W-1:0] : awr_q;
        err_d = err_q | ~in_range;
      end else if (op == OP_WRITE) begin
        awr_d = adv(awr_q);
      end else if (op == OP_SET_RADDR) begin
        ard_d = in_range ? pl[ADDR_W-1:0] : ard_q;
        err_d = err_q | ~in_range;
      end else begin
        ard_d      = adv(ard_q);
        rem_d      = pl[ADDR_W-1:0];
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end
    end
    if (pop) begin
      ard_d      = (rem_q != '0) ? adv(ard_q) : ard_q;
      rem_d      = (rem_q != '0) ? rem_q - 1'b1 : rem_q;
      tx_valid_d = rem_q != '0;
      state_d    = (rem_q != '0) ? SEND : IDLE;
    end
  end
  // control state; async reset abandons any burst in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      awr_q      <= '0;
      ard_q      <= '0;
      rem_q      <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      awr_q      <= awr_d;
      ard_q      <= ard_d;
      rem_q      <= rem_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  ram_sp_array #(.DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (awr_q),
    .wdata (pl),
    .re    (re),
    .raddr (ard_q),
    .rdata (dout)
  );
  assign rx_ready = state_q == IDLE;
  assign busy     = state_q == SEND;
  assign tx_valid = tx_valid_q;
  assign err      = err_q;
endmodule

// File: tb/tb_spi_ram_burst.sv
// tb_spi_ram_burst: three parameter variants driven in lockstep and checked against a word-queue model
module tb_spi_ram_burst;
  logic       clk, rst_n, rx_valid, tx_ready;
  logic [9:0] din;
  logic [7:0] dw [3];
  logic       txv [3], rxr [3], bsy [3], erw [3];
  int checks = 0, errors = 0;

  spi_ram_burst u0 (.clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .rx_ready(rxr[0]),
    .dout(dw[0]), .tx_valid(txv[0]), .tx_ready(tx_ready), .busy(bsy[0]), .err(erw[0]));
  spi_ram_burst #(.MEM_DEPTH(200)) u1 (.clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .rx_ready(rxr[1]), .dout(dw[1]), .tx_valid(txv[1]), .tx_ready(tx_ready), .busy(bsy[1]), .err(erw[1]));
  spi_ram_burst #(.AUTO_INC(0)) u2 (.clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .rx_ready(rxr[2]), .dout(dw[2]), .tx_valid(txv[2]), .tx_ready(tx_ready), .busy(bsy[2]), .err(erw[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got=%h expected=%h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // model: memory image with known-flags, address registers, and the words a pending burst must present
  int         depth [3] = '{256, 200, 256};
  bit         inc [3]   = '{1'b1, 1'b1, 1'b0};
  logic [7:0] m_mem [3][256];
  bit         m_kn [3][256];
  int         m_awr [3], m_ard [3];
  bit         m_err [3], m_lastk [3];
  logic [7:0] m_last [3];
  logic [7:0] bw [3][256];
  bit         bk [3][256];
  int         head = 0, len = 0;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_awr[k] = 0; m_ard[k] = 0; m_err[k] = 0; m_last[k] = 8'h00; m_lastk[k] = 1;
      for (int a = 0; a < 256; a++) m_kn[k][a] = 0;
    end
    head = 0; len = 0;
  endtask

  task automatic model_step();
    logic [1:0] op;
    logic [7:0] p;
    op = din[9:8];
    p  = din[7:0];
    if (len > 0) begin
      if (tx_ready) begin
        for (int k = 0; k < 3; k++) begin m_last[k] = bw[k][head]; m_lastk[k] = bk[k][head]; end
        head++;
        if (head == len) begin head = 0; len = 0; end
      end
    end else if (rx_valid) begin
      for (int k = 0; k < 3; k++) begin
        if (op == 2'b00) begin
          if (p < depth[k]) m_awr[k] = p; else m_err[k] = 1;
        end else if (op == 2'b01) begin
          m_mem[k][m_awr[k]] = p; m_kn[k][m_awr[k]] = 1;
          if (inc[k]) m_awr[k] = (m_awr[k] + 1) % depth[k];
        end else if (op == 2'b10) begin
          if (p < depth[k]) m_ard[k] = p; else m_err[k] = 1;
        end else begin
          for (int i = 0; i <= int'(p); i++) begin
            bw[k][i] = m_mem[k][m_ard[k]]; bk[k][i] = m_kn[k][m_ard[k]];
            if (inc[k]) m_ard[k] = (m_ard[k] + 1) % depth[k];
          end
        end
      end
      if (op == 2'b11) begin len = int'(p) + 1; head = 0; end
    end
  endtask

  // every falling edge: outputs must match the model, then the model takes the coming rising edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      for (int k = 0; k < 3; k++) begin
        chk("tx_valid", k, 32'(txv[k]), 32'(len > 0));
        chk("rx_ready", k, 32'(rxr[k]), 32'(len == 0));
        chk("busy", k, 32'(bsy[k]), 32'(len > 0));
        chk("err", k, 32'(erw[k]), 32'(m_err[k]));
        if (len > 0 ? bk[k][head] : m_lastk[k])
          chk("dout", k, 32'(dw[k]), 32'(len > 0 ? bw[k][head] : m_last[k]));
      end
      if (rst_n) model_step();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] p);
    int n = 0;
    while (!rxr[0] && n < 300) begin cyc(); n++; end
    if (n >= 300) chk("rx_ready_wait", 0, 32'(rxr[0]), 32'd1);
    din = {op, p}; rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    tx_ready = 1'b1;
    while (txv[0] && n < 300) begin cyc(); n++; end
    if (n >= 300) chk("drain_wait", 0, 32'(txv[0]), 32'd0);
    tx_ready = 1'b0;
  endtask

  logic [7:0] got [$];
  logic [7:0] exp2 [4];
  bit         pat [6];

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0; din = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("reset_rx_ready", 0, 32'(rxr[0]), 32'd1);
    chk("reset_tx_valid", 0, 32'(txv[0]), 32'd0);
    chk("reset_err", 0, 32'(erw[0]), 32'd0);
    chk("reset_dout", 0, 32'(dw[0]), 32'h00);
    // single write / read with back-pressure
    send(2'b00, 8'h10); send(2'b01, 8'hA5); send(2'b10, 8'h10); send(2'b11, 8'h00);
    for (int k = 0; k < 3; k++) begin
      chk("single_dout", k, 32'(dw[k]), 32'hA5);
      chk("single_valid", k, 32'(txv[k]), 32'd1);
    end
    repeat (3) begin cyc(); chk("single_hold", 0, 32'(dw[0]), 32'hA5); end
    tx_ready = 1'b1; cyc(); tx_ready = 1'b0;
    chk("single_done_valid", 0, 32'(txv[0]), 32'd0);
    chk("single_done_ready", 0, 32'(rxr[0]), 32'd1);
    // range error on the 200-deep variant; next write lands at the old address 0x11
    send(2'b00, 8'hC8);
    chk("range_err_d200", 1, 32'(erw[1]), 32'd1);
    chk("range_ok_d256", 0, 32'(erw[0]), 32'd0);
    send(2'b01, 8'h5A);
    send(2'b10, 8'hC7);
    chk("range_c7_err_sticky", 1, 32'(erw[1]), 32'd1);
    send(2'b10, 8'h11); send(2'b11, 8'h00);
    chk("range_write_addr", 1, 32'(dw[1]), 32'h5A);
    drain();
    // wrapping auto-increment burst with tx_ready 1,0,1,1,0,1
    send(2'b00, 8'hFE);
    for (int i = 1; i <= 4; i++) send(2'b01, 8'(i));
    send(2'b10, 8'hFE); send(2'b11, 8'h03);
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    got.delete();
    for (int i = 0; i < 6; i++) begin
      tx_ready = pat[i];
      if (txv[0] && tx_ready) got.push_back(dw[0]);
      cyc();
    end
    tx_ready = 1'b0;
    exp2 = '{8'h01, 8'h02, 8'h03, 8'h04};
    chk("burst_count", 0, 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("burst_word", 0, 32'(got[i]), 32'(exp2[i]));
    chk("burst_end_valid", 0, 32'(txv[0]), 32'd0);
    // commands offered during a burst are ignored
    send(2'b10, 8'h10); send(2'b11, 8'h02);
    din = {2'b01, 8'h77}; rx_valid = 1'b1;
    repeat (3) begin cyc(); chk("busy_rx_ready", 0, 32'(rxr[0]), 32'd0); end
    rx_valid = 1'b0;
    drain();
    send(2'b00, 8'hC9); send(2'b01, 8'h66); send(2'b10, 8'hC9); send(2'b11, 8'h00);
    chk("ignored_write", 0, 32'(dw[0]), 32'h66);
    drain();
    // asynchronous reset during the second word of a four-word burst
    send(2'b10, 8'h10); send(2'b11, 8'h03);
    tx_ready = 1'b1; cyc(); tx_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_tx_valid", k, 32'(txv[k]), 32'd0);
      chk("rst_busy", k, 32'(bsy[k]), 32'd0);
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_rx_ready", 0, 32'(rxr[0]), 32'd1);
    send(2'b00, 8'h00); send(2'b01, 8'hE7); send(2'b11, 8'h00);
    for (int k = 0; k < 3; k++) chk("rst_raddr_zero", k, 32'(dw[k]), 32'hE7);
    drain();
    // non-incrementing variant repeats one address for the whole burst
    send(2'b00, 8'h05); send(2'b01, 8'h3C); send(2'b10, 8'h05); send(2'b11, 8'h02);
    got.delete();
    tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (txv[2]) got.push_back(dw[2]);
      cyc();
    end
    tx_ready = 1'b0;
    chk("noinc_count", 2, 32'(got.size()), 32'd3);
    for (int i = 0; i < got.size(); i++) chk("noinc_word", 2, 32'(got[i]), 32'h3C);
    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
